// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register bank with buffered write-back.
// Contents: register address width, the write-back queue entry layout and
// the hardwired-zero register index.
package regfile_pkg;

  localparam int DATA_BITS     = 32;
  localparam int NUM_REGS      = 32;
  localparam int REG_ADDR_BITS = $clog2(NUM_REGS);

  localparam logic [REG_ADDR_BITS-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0]     data;
  } wbq_entry_t;

endpackage

// File: rtl/regfile_wb_bank_wbq_fifo.sv
// wbq_fifo: in-order write-back queue.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, din      enqueue request and entry (ignored while full)
//   pop            dequeue request (ignored while empty)
//   count          occupied entries
//   ord_flat       all slots in age order, slot 0 = head (oldest)
//   ord_valid      per age-ordered slot, 1 when occupied
module wbq_fifo
  import regfile_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH*WIDTH-1:0]   ord_flat,
  output logic [DEPTH-1:0]         ord_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head, tail;
  logic             do_push, do_pop;

  assign do_push = push && (count < DEPTH_C);
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign ord_flat[k*WIDTH +: WIDTH] = mem[head + PW'(k)];
    assign ord_valid[k]               = (CW'(k) < count);
  end

endmodule

// File: rtl/regfile_wb_bank.sv
// regfile_wb_bank: integer register bank fed by a buffered write-back queue,
// with two combinational read ports. One queued write commits per cycle.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   wr_valid/wr_ready        write-back handshake; wr_addr/wr_data payload
//   rs1_addr/rs2_addr        read addresses
//   rs1_data/rs2_data        read values (x0 reads zero)
//   rs1_pending/rs2_pending  an uncommitted write to that register is queued
//   wbq_count                occupied queue entries
// Build option REGFILE_BYPASS_EN: reads forward the youngest queued write to
// the addressed register and the pending flags are tied low.
module regfile_wb_bank
  import regfile_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int NUM_REGS  = 32,
  parameter int WBQ_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(NUM_REGS)-1:0]  wr_addr,
  input  logic [DATA_BITS-1:0]         wr_data,
  input  logic [$clog2(NUM_REGS)-1:0]  rs1_addr,
  input  logic [$clog2(NUM_REGS)-1:0]  rs2_addr,
  output logic [DATA_BITS-1:0]         rs1_data,
  output logic [DATA_BITS-1:0]         rs2_data,
  output logic                         rs1_pending,
  output logic                         rs2_pending,
  output logic [$clog2(WBQ_DEPTH):0]   wbq_count
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(WBQ_DEPTH) + 1;
  localparam int EW = AW + DATA_BITS;
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [WBQ_DEPTH*EW-1:0] q_flat;
  logic [WBQ_DEPTH-1:0]    q_valid;
  logic [AW-1:0]           q_addr [WBQ_DEPTH];
  logic [DATA_BITS-1:0]    q_data [WBQ_DEPTH];

  logic [DATA_BITS-1:0]    bank [NUM_REGS];
  logic [NUM_REGS-1:0]     commit_oh;

  logic [AW-1:0]           rd_addr [2];
  logic [DATA_BITS-1:0]    rd_data [2];
  logic                    rd_pend [2];

  // Ready looks only at occupancy, so a full queue refuses a push even when
  // the head retires on the same edge.
  assign wr_ready = (wbq_count < CW'(WBQ_DEPTH));

  wbq_fifo #(.WIDTH(EW), .DEPTH(WBQ_DEPTH)) u_wbq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_valid && wr_ready),
    .din       ({wr_addr, wr_data}),
    .pop       (1'b1),
    .count     (wbq_count),
    .ord_flat  (q_flat),
    .ord_valid (q_valid)
  );

  for (genvar k = 0; k < WBQ_DEPTH; k++) begin : g_unpack
    assign q_addr[k] = q_flat[k*EW+DATA_BITS +: AW];
    assign q_data[k] = q_flat[k*EW +: DATA_BITS];
  end

  // Head entry retires every non-empty cycle; x0 writes are simply dropped.
  always_comb begin
    commit_oh = '0;
    if (q_valid[0] && q_addr[0] != ZERO_ADDR) commit_oh[q_addr[0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_oh[i]) bank[i] <= q_data[0];
      end
    end
  end

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  // Scanning oldest to youngest lets the youngest match win when forwarding.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = (rd_addr[p] == ZERO_ADDR) ? '0 : bank[rd_addr[p]];
      rd_pend[p] = 1'b0;
      for (int k = 0; k < WBQ_DEPTH; k++) begin
        if (q_valid[k] && q_addr[k] == rd_addr[p] && rd_addr[p] != ZERO_ADDR) begin
`ifdef REGFILE_BYPASS_EN
          rd_data[p] = q_data[k];
`else
          rd_pend[p] = 1'b1;
`endif
        end
      end
    end
  end

  assign rs1_data    = rd_data[0];
  assign rs2_data    = rd_data[1];
  assign rs1_pending = rd_pend[0];
  assign rs2_pending = rd_pend[1];

endmodule

// File: tb/tb_regfile_wb_bank.sv
module tb_regfile_wb_bank;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_pending, rs2_pending;
  logic [2:0]  wbq_count;

  int checks = 0;
  int errors = 0;

  wbq_entry_t  mq[$];
  logic [31:0] mbank [32];

  regfile_wb_bank #(.DATA_BITS(32), .NUM_REGS(32), .WBQ_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .wbq_count   (wbq_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    logic [31:0] r;
    r = (a == 5'd0) ? 32'd0 : mbank[a];
`ifdef REGFILE_BYPASS_EN
    foreach (mq[i]) if (a != 5'd0 && mq[i].addr == a) r = mq[i].data;
`endif
    return r;
  endfunction

  function automatic logic exp_pend(input logic [4:0] a);
    logic r;
    r = 1'b0;
`ifndef REGFILE_BYPASS_EN
    foreach (mq[i]) if (a != 5'd0 && mq[i].addr == a) r = 1'b1;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".count"},    32'(wbq_count),   32'(mq.size()));
    chk({tag, ".ready"},    32'(wr_ready),    32'(mq.size() < DEPTH));
    chk({tag, ".rs1_data"}, rs1_data,         exp_data(rs1_addr));
    chk({tag, ".rs1_pend"}, 32'(rs1_pending), 32'(exp_pend(rs1_addr)));
    chk({tag, ".rs2_data"}, rs2_data,         exp_data(rs2_addr));
    chk({tag, ".rs2_pend"}, 32'(rs2_pending), 32'(exp_pend(rs2_addr)));
  endtask

  task automatic reset_model();
    mq.delete();
    for (int i = 0; i < 32; i++) mbank[i] = '0;
  endtask

  // One clock: drive a request, advance the model across the edge, then check
  // all outputs and verify that the retired entry landed in the bank.
  task automatic cycle(input string tag, input logic v, input logic [4:0] a,
                       input logic [31:0] d);
    wbq_entry_t e, n;
    logic       popped, accepted;
    logic [4:0] save;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    @(posedge clk);
    popped   = (mq.size() > 0);
    accepted = v && (mq.size() < DEPTH);
    e = '0;
    if (popped) begin
      e = mq.pop_front();
      if (e.addr != 5'd0) mbank[e.addr] = e.data;
    end
    if (accepted) begin
      n.addr = a;
      n.data = d;
      mq.push_back(n);
    end
    #2;
    wr_valid = 1'b0;
    check_outputs(tag);
    if (popped && e.addr != 5'd0) begin
      save = rs2_addr;
      rs2_addr = e.addr;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk({tag, ".commit"}, rs2_data, exp_data(e.addr));
`else
      chk({tag, ".commit"}, rs2_data, e.data);
`endif
      rs2_addr = save;
      #1;
    end
  endtask

  initial begin
    reset_model();
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic write then read
    rs1_addr = 5'd5;
    rs2_addr = 5'd0;
    cycle("basic_push", 1'b1, 5'd5, 32'hDEADBEEF);
    cycle("basic_commit", 1'b0, 5'd0, 32'd0);
    cycle("basic_idle", 1'b0, 5'd0, 32'd0);

    // x0 write is discarded
    rs1_addr = 5'd0;
    cycle("x0_push", 1'b1, 5'd0, 32'h12345678);
    cycle("x0_commit", 1'b0, 5'd0, 32'd0);

    // back-to-back pushes: queue stays at one entry, ready never drops
    rs1_addr = 5'd1;
    rs2_addr = 5'd4;
    for (int i = 1; i <= 4; i++)
      cycle("stream", 1'b1, 5'(i), 32'hC0DE_0000 + 32'(i));
    cycle("stream_drain", 1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      rs1_addr = 5'(i);
      #1;
      chk("stream_bank", rs1_data, 32'hC0DE_0000 + 32'(i));
    end

    // same register, last write wins
    rs1_addr = 5'd7;
    cycle("same_w1", 1'b1, 5'd7, 32'h1);
    cycle("same_w2", 1'b1, 5'd7, 32'h2);
    cycle("same_w3", 1'b1, 5'd7, 32'h3);
    cycle("same_drain", 1'b0, 5'd0, 32'd0);
    chk("same_final", rs1_data, 32'h3);

    // two writes to x9 observed on rs2
    rs2_addr = 5'd9;
    cycle("byp_a", 1'b1, 5'd9, 32'hA);
    cycle("byp_b", 1'b1, 5'd9, 32'hB);
    cycle("byp_drain", 1'b0, 5'd0, 32'd0);

    // reset with a write still queued
    rs1_addr = 5'd12;
    rs2_addr = 5'd9;
    cycle("mid_p1", 1'b1, 5'd10, 32'h100);
    cycle("mid_p2", 1'b1, 5'd11, 32'h200);
    cycle("mid_p3", 1'b1, 5'd12, 32'h300);
    rst_n = 1'b0;
    reset_model();
    #1;
    check_outputs("mid_reset");
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_reset1", 1'b0, 5'd0, 32'd0);
    rs1_addr = 5'd11;
    rs2_addr = 5'd10;
    cycle("post_reset2", 1'b0, 5'd0, 32'd0);

    // random traffic, including x0 and repeated addresses
    for (int i = 0; i < 60; i++) begin
      rs1_addr = 5'($urandom_range(0, 15));
      rs2_addr = 5'($urandom_range(0, 15));
      cycle("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
    end
    cycle("rand_drain", 1'b0, 5'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
